nn_layer_ctrl: RTL
==================

// Module: nn_layer_ctrl
// PURPOSE
//  Sequencer for one fully-connected layer of the Simple NN datapath.
//  Loads the input-vector registers (14-bit Reg14 enables). For each neuron it
//  drives N_INPUTS multiply-accumulate steps over the shared MAC, then one
//  activation step and one output-register write. Start/done handshake to the
//  top-level controller.
// PARAMETERS
//  N_INPUTS   4   inputs per neuron (>=2); MAC steps per neuron
//  N_NEURONS  2   neurons in the layer (>=1); output registers written
//  IW         $clog2(N_INPUTS)            in_sel width (derived localparam)
//  NW         $clog2(N_NEURONS) (min 1)   out_sel width (derived localparam)
//  WW         $clog2(N_INPUTS*N_NEURONS)  w_addr width (derived localparam)
// PORTS
//  Clk        in   1   clock, rising edge
//  Rst        in   1   asynchronous active-low reset
//  start      in   1   start request, sampled in IDLE only
//  abort      in   1   synchronous abort, returns to IDLE without done
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle pulse, layer finished
//  x_ld_en    out  1   enable for input-vector registers
//  in_sel     out  IW  input-vector mux select for MAC operand A
//  w_addr     out  WW  weight ROM address = neuron*N_INPUTS + in_sel
//  acc_clr    out  1   accumulator loads product instead of sum
//  acc_en     out  1   accumulator enable
//  act_en     out  1   activation-stage register enable
//  out_we     out  1   output-register write enable
//  out_sel    out  NW  output-register index (current neuron)
// BEHAVIOUR
//  - Reset (Rst=0, async): state IDLE, all counters 0, all outputs 0.
//  - FSM: IDLE -> LOAD -> MAC -> [BIAS] -> ACT -> WRITE -> (MAC | DONE) -> IDLE.
//  - IDLE: start=1 -> LOAD. start in any other state is ignored.
//  - LOAD (1 cycle): x_ld_en=1. neuron cnt j=0, input cnt i=0.
//  - MAC (N_INPUTS cycles): acc_en=1, in_sel=i, w_addr=j*N_INPUTS+i.
//    acc_clr=1 only when i=0. i increments each cycle; at i=N_INPUTS-1,
//    i wraps to 0 and the FSM leaves MAC.
//  - ACT (1 cycle): act_en=1, out_sel=j.
//  - WRITE (1 cycle): out_we=1, out_sel=j.
//    If j<N_NEURONS-1: j++ and go to MAC. Else go to DONE.
//  - DONE (1 cycle): done=1, busy=1. Next state IDLE.
//  - All control outputs are registered-state decodes, 0 outside their state.
//  - Latency: start sampled at edge E0. done is high in the cycle after edge
//    E(1+N_NEURONS*(N_INPUTS+2)); with defaults that is E13.
//  - abort=1 in any non-IDLE state: next state IDLE, counters cleared, no done.
//    Abort wins over every other transition. Abort in IDLE has no effect.
//  - start and abort both high in IDLE: abort wins, stay IDLE.
//  - Reset mid-layer: immediate IDLE, no done. Restart requires a new start.
// CONFIGURATION
//  NN_CTRL_BIAS_EN defined:
//   - Extra output bias_en (1 bit, reset 0).
//   - State BIAS (1 cycle) between MAC and ACT. In BIAS: bias_en=1, acc_en=1,
//     out_sel=j.
//   - Latency: done follows edge E(1+N_NEURONS*(N_INPUTS+3)); defaults give E15.
//  NN_CTRL_BIAS_EN undefined: no bias_en port, no BIAS state; MAC -> ACT.
// TESTING
//  1 Reset: Rst=0 mid-MAC -> all outputs 0 at once; state IDLE after release.
//  2 Defaults, start pulse -> x_ld_en 1 cycle; 4 MAC cycles w_addr 0,1,2,3
//    with acc_clr on w_addr 0; act, write out_sel=0; then w_addr 4..7 and
//    out_sel=1; done at E13; busy high E1..E13.
//  3 start held high through and after done -> exactly one run. A second run
//    starts only from IDLE (done at E13, next LOAD E15).
//  4 abort during neuron 1, MAC i=2 -> IDLE next cycle, no out_we for
//    neuron 1, no done. start then gives a full run from w_addr 0.
//  5 start+abort together in IDLE -> stays IDLE, busy=0.
//  6 With NN_CTRL_BIAS_EN: bias_en 1 cycle after each MAC group (2 pulses);
//    done at E15. N_INPUTS=3, N_NEURONS=1 without macro -> done at E6.

Source files
------------

// File: rtl/nn_layer_ctrl.sv
// Control sequencer for one fully-connected NN layer: input load, per-neuron MAC sweep,
// activation and output write. Optional BIAS step per neuron when NN_CTRL_BIAS_EN is defined.
module nn_layer_ctrl #(
   parameter  int N_INPUTS  = 4,
   parameter  int N_NEURONS = 2,
   localparam int IW        = $clog2(N_INPUTS),
   localparam int NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
   localparam int WW        = $clog2(N_INPUTS * N_NEURONS)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          x_ld_en,
   output logic [IW-1:0] in_sel,
   output logic [WW-1:0] w_addr,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          act_en,
   output logic          out_we,
   output logic [NW-1:0] out_sel
`ifdef NN_CTRL_BIAS_EN
   ,
   output logic          bias_en
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_BIAS,
      S_ACT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [IW-1:0] I_LAST = IW'(N_INPUTS - 1);
   localparam logic [NW-1:0] J_LAST = NW'(N_NEURONS - 1);

   state_t        state, state_nx;
   logic [IW-1:0] i_cnt, i_nx;
   logic [NW-1:0] j_cnt, j_nx;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= S_IDLE;
         i_cnt <= '0;
         j_cnt <= '0;
      end else begin
         state <= state_nx;
         i_cnt <= i_nx;
         j_cnt <= j_nx;
      end
   end

   always_comb begin
      state_nx = state;
      i_nx     = i_cnt;
      j_nx     = j_cnt;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_LOAD;
         end
         S_LOAD: begin
            i_nx     = '0;
            j_nx     = '0;
            state_nx = S_MAC;
         end
         S_MAC: begin
            if (i_cnt == I_LAST) begin
               i_nx = '0;
`ifdef NN_CTRL_BIAS_EN
               state_nx = S_BIAS;
`else
               state_nx = S_ACT;
`endif
            end else begin
               i_nx = i_cnt + IW'(1);
            end
         end
`ifdef NN_CTRL_BIAS_EN
         S_BIAS:  state_nx = S_ACT;
`endif
         S_ACT:   state_nx = S_WRITE;
         S_WRITE: begin
            if (j_cnt == J_LAST) begin
               state_nx = S_DONE;
            end else begin
               j_nx     = j_cnt + NW'(1);
               state_nx = S_MAC;
            end
         end
         S_DONE: begin
            j_nx     = '0;
            state_nx = S_IDLE;
         end
         default: begin
            i_nx     = '0;
            j_nx     = '0;
            state_nx = S_IDLE;
         end
      endcase
      // Abort overrides every transition; in IDLE it also masks a coincident start.
      if (abort) begin
         state_nx = S_IDLE;
         i_nx     = '0;
         j_nx     = '0;
      end
   end

   // Pure decodes of registered state/counters: every output is 0 in IDLE.
   always_comb begin
      busy    = (state != S_IDLE);
      done    = (state == S_DONE);
      x_ld_en = (state == S_LOAD);
      acc_en  = (state == S_MAC);
      acc_clr = (state == S_MAC) && (i_cnt == '0);
      act_en  = (state == S_ACT);
      out_we  = (state == S_WRITE);
      in_sel  = '0;
      w_addr  = '0;
      out_sel = '0;
      if (state == S_MAC) begin
         in_sel = i_cnt;
         w_addr = WW'(int'(j_cnt) * N_INPUTS + int'(i_cnt));
      end
      if (state == S_ACT || state == S_WRITE) out_sel = j_cnt;
`ifdef NN_CTRL_BIAS_EN
      bias_en = (state == S_BIAS);
      if (state == S_BIAS) begin
         acc_en  = 1'b1;
         out_sel = j_cnt;
      end
`endif
   end

endmodule
